// File: rtl/mem_wb_if.sv
// Memory-stage to writeback bundle: in_* come from the memory stage, wb_* go to
// the register file and forwarding unit.
interface mem_wb_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_reg_write;
  logic [4:0]      in_rd;
  logic [1:0]      in_wb_sel;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_read_data;
  logic [XLEN-1:0] in_pc_plus4;
  logic            wb_valid;
  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
           in_alu_result, in_read_data, in_pc_plus4,
    input  wb_valid, wb_reg_write, wb_rd, wb_data
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
           in_alu_result, in_read_data, in_pc_plus4,
    output wb_valid, wb_reg_write, wb_rd, wb_data
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load formatting, writeback mux and instret.
// Define MEM_WB_LOAD_ALIGN_EN to build in load byte/halfword extraction.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  mem_wb_if.slave     bus,
  output logic [63:0] instret
);

  logic [XLEN-1:0] load_fmt;
  logic [XLEN-1:0] wb_data_d, wb_data_q;
  logic [4:0]      wb_rd_q;
  logic            wb_reg_write_d, wb_reg_write_q;
  logic            wb_valid_q;
  logic [63:0]     instret_q;

`ifdef MEM_WB_LOAD_ALIGN_EN
  logic [1:0]  off;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign off    = bus.in_alu_result[1:0];
  assign byte_v = bus.in_read_data[{off, 3'b000} +: 8];
  assign half_v = off[1] ? bus.in_read_data[31:16] : bus.in_read_data[15:0];

  always_comb begin
    load_fmt = bus.in_read_data;
    case (bus.in_funct3)
      3'b000:  load_fmt = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_fmt = {{16{half_v[15]}}, half_v};
      3'b100:  load_fmt = {24'd0, byte_v};
      3'b101:  load_fmt = {16'd0, half_v};
      default: load_fmt = bus.in_read_data;
    endcase
  end
`else
  // Memory stage already delivers formatted load data.
  logic unused_fmt;
  assign unused_fmt = ^{bus.in_funct3, bus.in_alu_result[1:0]};
  assign load_fmt   = bus.in_read_data;
`endif

  always_comb begin
    wb_data_d = bus.in_alu_result;
    case (bus.in_wb_sel)
      2'b01:   wb_data_d = load_fmt;
      2'b10:   wb_data_d = bus.in_pc_plus4;
      default: wb_data_d = bus.in_alu_result;
    endcase
  end

  // x0 writes are dropped here so the register file never sees them.
  assign wb_reg_write_d = bus.in_valid & bus.in_reg_write & (bus.in_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= '0;
      instret_q      <= 64'd0;
    end else if (flush) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= '0;
    end else if (!stall) begin
      wb_valid_q     <= bus.in_valid;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= bus.in_rd;
      wb_data_q      <= wb_data_d;
      if (bus.in_valid) instret_q <= instret_q + 64'd1;
    end
  end

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_reg_write = wb_reg_write_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign instret          = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; load expectations follow MEM_WB_LOAD_ALIGN_EN.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [63:0] instret;
  int          n_chk = 0;
  int          n_fail = 0;

  mem_wb_if #(.XLEN(32)) bus();

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [31:0] pc4);
    bus.in_valid      = v;
    bus.in_reg_write  = rw;
    bus.in_rd         = rd;
    bus.in_wb_sel     = sel;
    bus.in_funct3     = f3;
    bus.in_alu_result = alu;
    bus.in_read_data  = rdat;
    bus.in_pc_plus4   = pc4;
  endtask

  localparam logic [31:0] WORD = 32'h80FF_7F01;
  typedef struct { string tag; logic [2:0] f3; logic [1:0] off; logic [31:0] exp; } ld_t;
  ld_t lds[6];
  logic [63:0] cnt;

  initial begin
`ifdef MEM_WB_LOAD_ALIGN_EN
    lds[0] = '{"lb_off1",  3'b000, 2'd1, 32'h0000_007F};
    lds[1] = '{"lb_off2",  3'b000, 2'd2, 32'hFFFF_FFFF};
    lds[2] = '{"lbu_off2", 3'b100, 2'd2, 32'h0000_00FF};
    lds[3] = '{"lh_off2",  3'b001, 2'd2, 32'hFFFF_80FF};
    lds[4] = '{"lhu_off0", 3'b101, 2'd0, 32'h0000_7F01};
    lds[5] = '{"lw",       3'b010, 2'd0, 32'h80FF_7F01};
`else
    lds[0] = '{"lb_off1",  3'b000, 2'd1, WORD};
    lds[1] = '{"lb_off2",  3'b000, 2'd2, WORD};
    lds[2] = '{"lbu_off2", 3'b100, 2'd2, WORD};
    lds[3] = '{"lh_off2",  3'b001, 2'd2, WORD};
    lds[4] = '{"lhu_off0", 3'b101, 2'd0, WORD};
    lds[5] = '{"lw",       3'b010, 2'd0, WORD};
`endif
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 5'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom);
      cyc();
    end
    chk("rst_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("rst_rw",    {63'd0, bus.wb_reg_write}, 64'd0);
    chk("rst_rd",    {59'd0, bus.wb_rd}, 64'd0);
    chk("rst_data",  {32'd0, bus.wb_data}, 64'd0);
    chk("rst_instret", instret, 64'd0);

    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
    cyc();
    chk("idle_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("idle_data",  {32'd0, bus.wb_data}, 64'd0);
    chk("idle_instret", instret, 64'd0);

    cnt = 0;
    foreach (lds[i]) begin
      drive(1'b1, 1'b1, 5'd7, 2'b01, lds[i].f3, {30'h0000_0400, lds[i].off}, WORD, 32'h44);
      cyc();
      cnt++;
      chk(lds[i].tag, {32'd0, bus.wb_data}, {32'd0, lds[i].exp});
    end
    chk("load_rd", {59'd0, bus.wb_rd}, 64'd7);
    chk("load_instret", instret, cnt);

    drive(1'b1, 1'b1, 5'd5, 2'b10, 3'b000, 32'h0000_0AAA, 32'h5555_5555, 32'h104);
    cyc(); cnt++;
    chk("pc4_data", {32'd0, bus.wb_data}, 64'h104);
    chk("pc4_rw",   {63'd0, bus.wb_reg_write}, 64'd1);
    bus.in_rd = 5'd0;
    cyc(); cnt++;
    chk("x0_rw",    {63'd0, bus.wb_reg_write}, 64'd0);
    chk("x0_valid", {63'd0, bus.wb_valid}, 64'd1);
    drive(1'b1, 1'b1, 5'd9, 2'b11, 3'b000, 32'h1234_5678, WORD, 32'h200);
    cyc(); cnt++;
    chk("sel11_alu", {32'd0, bus.wb_data}, 64'h1234_5678);
    drive(1'b1, 1'b0, 5'd9, 2'b00, 3'b000, 32'h1111_0000, WORD, 32'h200);
    cyc(); cnt++;
    chk("norw_rw", {63'd0, bus.wb_reg_write}, 64'd0);

    drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'hDEAD_BEEF, WORD, 32'h300);
    cyc(); cnt++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(i + 10), 2'b00, 3'b000, 32'h0BAD_0000 + i, WORD, 32'h400);
      cyc();
      chk("stall_data", {32'd0, bus.wb_data}, 64'hDEAD_BEEF);
      chk("stall_rd",   {59'd0, bus.wb_rd}, 64'd3);
      chk("stall_instret", instret, cnt);
    end

    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'hCAFE_F00D, WORD, 32'h500);
    cyc();
    chk("flush_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("flush_rw",    {63'd0, bus.wb_reg_write}, 64'd0);
    chk("flush_data",  {32'd0, bus.wb_data}, 64'd0);
    chk("flush_rd",    {59'd0, bus.wb_rd}, 64'd0);
    chk("flush_instret", instret, cnt);

    flush = 1'b0; stall = 1'b0;
    cyc(); cnt++;
    chk("post_flush_data", {32'd0, bus.wb_data}, 64'hCAFE_F00D);
    stall = 1'b1; rst = 1'b1;
    cyc();
    chk("rst_stall_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("rst_stall_data",  {32'd0, bus.wb_data}, 64'd0);
    chk("rst_stall_instret", instret, 64'd0);

    rst = 1'b0; stall = 1'b0;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    chk("force_instret", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b1, 1'b1, 5'd1, 2'b00, 3'b000, 32'h1, WORD, 32'h0);
    cyc();
    chk("wrap_instret", instret, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
